video_sync_gen: RTL

//  Master horizontal/vertical timing generator for the Breakout video chain.
//  - Sits directly upstream of the playfield, ball and paddle decoders.
//  - Produces the free-running H and V counters whose bits (_8H.._128H, _4V.._128V)

---
 rtl/breakout_video_pkg.sv | 23 ++
 rtl/mod_counter.sv | 51 +++++
 rtl/video_sync_gen.sv | 111 +++++++++++
 3 files changed

// File: rtl/breakout_video_pkg.sv
// Shared types and default raster timing for the Breakout video chain.
package breakout_video_pkg;

  localparam int CNT_W = 9;

  // Default raster: 454 pixel clocks per line, 262 lines per frame.
  localparam int DEF_H_TOTAL      = 454;
  localparam int DEF_HBLANK_START = 374;
  localparam int DEF_HSYNC_START  = 390;
  localparam int DEF_HSYNC_END    = 421;
  localparam int DEF_V_TOTAL      = 262;
  localparam int DEF_VBLANK_START = 240;
  localparam int DEF_VSYNC_START  = 248;
  localparam int DEF_VSYNC_END    = 251;

  typedef logic [CNT_W-1:0] cnt_t;

  // Inclusive range test used by the sync decoders.
  function automatic logic in_range(input cnt_t val, input cnt_t lo, input cnt_t hi);
    return (val >= lo) && (val <= hi);
  endfunction

endpackage

// File: rtl/mod_counter.sv
// Modulo-N counter with increment enable, a look-ahead next value and a wrap carry.
module mod_counter
  import breakout_video_pkg::*;
#(
  parameter int MODULUS = DEF_H_TOTAL
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_count,
  output logic [CNT_W-1:0] o_count_next,
  output logic             o_carry
);

  localparam cnt_t LAST = cnt_t'(MODULUS - 1);

  cnt_t r_count;
  cnt_t w_count_next;
  logic w_at_last;

  // ">=" rather than "==" so an out-of-range value wraps to 0 on the next step.
  assign w_at_last = (r_count >= LAST);
  assign o_carry   = i_inc & w_at_last;

  // Next count: hold, step, or wrap to zero.
  always_comb begin
    // NOTE: assign a default first so every path drives the signal; a missing branch would infer a latch.
    w_count_next = r_count;
    if (i_inc) begin
      if (w_at_last) begin
        w_count_next = '0;
      end else begin
        w_count_next = r_count + cnt_t'(1);
      end
    end
  end

  // Count register; reset wins over increment.
  always_ff @(posedge i_clk) begin
    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    if (i_reset) begin
      r_count <= '0;
    end else begin
      r_count <= w_count_next;
    end
  end

  assign o_count      = r_count;
  assign o_count_next = w_count_next;

endmodule

// File: rtl/video_sync_gen.sv
// Master H/V timing generator: free-running counters plus registered sync, blank
// and frame-start outputs that line up with the counters they describe.
module video_sync_gen
  import breakout_video_pkg::*;
#(
  parameter int H_TOTAL      = DEF_H_TOTAL,
  parameter int HBLANK_START = DEF_HBLANK_START,
  parameter int HSYNC_START  = DEF_HSYNC_START,
  parameter int HSYNC_END    = DEF_HSYNC_END,
  parameter int V_TOTAL      = DEF_V_TOTAL,
  parameter int VBLANK_START = DEF_VBLANK_START,
  parameter int VSYNC_START  = DEF_VSYNC_START,
  parameter int VSYNC_END    = DEF_VSYNC_END
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_clk_en,
  output logic [CNT_W-1:0] o_hcnt,
  output logic [CNT_W-1:0] o_vcnt,
  output logic             o_hsync_n,
  output logic             o_vsync_n,
  output logic             o_hblank,
  output logic             o_vblank,
  output logic             o_frame_start
);

  // Timing parameters must fit the 9-bit counters and be correctly ordered.
  if (H_TOTAL > (1 << CNT_W) || V_TOTAL > (1 << CNT_W)) begin : g_bad_total
    $error("video_sync_gen: H_TOTAL and V_TOTAL must not exceed %0d", 1 << CNT_W);
  end
  if (!(HBLANK_START < HSYNC_START && HSYNC_START <= HSYNC_END && HSYNC_END < H_TOTAL)) begin : g_bad_h
    $error("video_sync_gen: need HBLANK_START < HSYNC_START <= HSYNC_END < H_TOTAL");
  end
  if (!(VBLANK_START < VSYNC_START && VSYNC_START <= VSYNC_END && VSYNC_END < V_TOTAL)) begin : g_bad_v
    $error("video_sync_gen: need VBLANK_START < VSYNC_START <= VSYNC_END < V_TOTAL");
  end

  localparam cnt_t HB_LO = cnt_t'(HBLANK_START);
  localparam cnt_t HS_LO = cnt_t'(HSYNC_START);
  localparam cnt_t HS_HI = cnt_t'(HSYNC_END);
  localparam cnt_t VB_LO = cnt_t'(VBLANK_START);
  localparam cnt_t VS_LO = cnt_t'(VSYNC_START);
  localparam cnt_t VS_HI = cnt_t'(VSYNC_END);

  cnt_t w_h_cnt;
  cnt_t w_h_next;
  logic w_h_carry;
  cnt_t w_v_cnt;
  cnt_t w_v_next;
  logic w_v_carry;
  logic w_v_inc;

  logic r_hsync_n;
  logic r_vsync_n;
  logic r_hblank;
  logic r_vblank;
  logic r_frame_start;

  // Lines advance only on the enabled edge that ends a line.
  assign w_v_inc = i_clk_en & w_h_carry;

  mod_counter #(
    .MODULUS (H_TOTAL)
  ) u_h_cnt (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_inc        (i_clk_en),
    .o_count      (w_h_cnt),
    .o_count_next (w_h_next),
    .o_carry      (w_h_carry)
  );

  mod_counter #(
    .MODULUS (V_TOTAL)
  ) u_v_cnt (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_inc        (w_v_inc),
    .o_count      (w_v_cnt),
    .o_count_next (w_v_next),
    .o_carry      (w_v_carry)
  );

  // Decode the upcoming count and register it with the counters, so sync and
  // blank change in the same cycle as the count they belong to.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_hsync_n     <= 1'b1;
      r_vsync_n     <= 1'b1;
      r_hblank      <= 1'b0;
      r_vblank      <= 1'b0;
      r_frame_start <= 1'b1;
    end else if (i_clk_en) begin
      r_hsync_n     <= ~in_range(w_h_next, HS_LO, HS_HI);
      r_vsync_n     <= ~in_range(w_v_next, VS_LO, VS_HI);
      r_hblank      <= (w_h_next >= HB_LO);
      r_vblank      <= (w_v_next >= VB_LO);
      // On an enabled edge the next count is (0,0) exactly when the frame wraps.
      r_frame_start <= w_v_carry;
    end
  end

  assign o_hcnt        = w_h_cnt;
  assign o_vcnt        = w_v_cnt;
  assign o_hsync_n     = r_hsync_n;
  assign o_vsync_n     = r_vsync_n;
  assign o_hblank      = r_hblank;
  assign o_vblank      = r_vblank;
  assign o_frame_start = r_frame_start;

endmodule
